// File: rtl/tft_rx.sv
// rtl/tft_rx.sv - TFT parallel RGB565 receiver with pixel coordinates and format lock
module tft_rx #(
    parameter int   EXP_H   = 480,
    parameter int   EXP_V   = 272,
    parameter logic VS_ACT  = 1'b0,
    parameter int   TIMEOUT = 1 << 20
) (
    input  logic        tft_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] rgb,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        tft_de,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        frame_start,
    output logic [9:0]  h_active,
    output logic [9:0]  v_active,
    output logic        fmt_locked,
    output logic        fmt_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] ST_UNLOCK = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [9:0] SAT       = 10'h3FF;

    logic [15:0]   rgb_s1;
    logic          de_s1, vs_s1, hs_s1, de_s2, vs_s2;
    logic [9:0]    col, row, first_len;
    logic          have_first, bad, good_cnt, to_done;
    logic [1:0]    state;
    logic [CW-1:0] cyc;

    logic vs_a1, vs_a2, vs_rise, de_fall, pix_ok, viol, frame_good, timeout_hit;
    logic hs_unused;

    // hsync is carried through the input register for alignment only
    assign hs_unused   = hs_s1;

    assign vs_a1       = (vs_s1 == VS_ACT);
    assign vs_a2       = (vs_s2 == VS_ACT);
    assign vs_rise     = vs_a1 & ~vs_a2;
    assign de_fall     = ~de_s1 & de_s2;
    assign pix_ok      = de_s1 & ~vs_a1;
    assign viol        = de_s1 & vs_a1;
    assign frame_good  = ~bad && (first_len == 10'(EXP_H)) && (row == 10'(EXP_V));
    // vsync in the same cycle suppresses the timeout; no timeout before the first vsync
    assign timeout_hit = (state != ST_UNLOCK) && !to_done && (cyc == CW'(TIMEOUT)) && !vs_rise;

    // Input register (stage 1) and edge-reference register (stage 2)
    always_ff @(posedge tft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rgb_s1 <= '0;
            de_s1  <= 1'b0;
            vs_s1  <= 1'b0;
            hs_s1  <= 1'b0;
            de_s2  <= 1'b0;
            vs_s2  <= 1'b0;
        end else begin
            rgb_s1 <= rgb;
            de_s1  <= tft_de;
            vs_s1  <= vsync;
            hs_s1  <= hsync;
            de_s2  <= de_s1;
            vs_s2  <= vs_s1;
        end
    end

    // Column/row counting, first-line length capture and frame-bad tracking
    always_ff @(posedge tft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            col        <= '0;
            row        <= '0;
            first_len  <= '0;
            have_first <= 1'b0;
            bad        <= 1'b0;
        end else if (vs_rise || timeout_hit) begin
            col        <= '0;
            row        <= '0;
            first_len  <= '0;
            have_first <= 1'b0;
            bad        <= vs_rise & viol;
        end else begin
            if (pix_ok) begin
                if (col != SAT) col <= col + 10'd1;
                if (col >= SAT - 10'd1) bad <= 1'b1;
            end
            if (viol) bad <= 1'b1;
            if (de_fall) begin
                col <= '0;
                if (row != SAT) row <= row + 10'd1;
                if (!have_first) begin
                    first_len  <= col;
                    have_first <= 1'b1;
                end else if (col != first_len) begin
                    bad <= 1'b1;
                end
            end
        end
    end

    // Cycles since the last vsync; the timeout fires once per vsync interval
    always_ff @(posedge tft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cyc     <= '0;
            to_done <= 1'b0;
        end else if (vs_rise) begin
            cyc     <= '0;
            to_done <= 1'b0;
        end else if (timeout_hit) begin
            to_done <= 1'b1;
        end else if (!to_done && cyc != CW'(TIMEOUT)) begin
            cyc <= cyc + CW'(1);
        end
    end

    // Lock FSM: frames are judged at each vsync once out of UNLOCK
    always_ff @(posedge tft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_UNLOCK;
            good_cnt <= 1'b0;
        end else if (vs_rise) begin
            case (state)
                ST_UNLOCK: begin
                    state    <= ST_CHECK;
                    good_cnt <= 1'b0;
                end
                ST_CHECK: begin
                    if (!frame_good) begin
                        good_cnt <= 1'b0;
                    end else if (good_cnt) begin
                        state    <= ST_LOCKED;
                        good_cnt <= 1'b0;
                    end else begin
                        good_cnt <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!frame_good) begin
                        state    <= ST_CHECK;
                        good_cnt <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_UNLOCK;
                    good_cnt <= 1'b0;
                end
            endcase
        end else if (timeout_hit) begin
            state    <= ST_UNLOCK;
            good_cnt <= 1'b0;
        end
    end

    // Output register: pixel stream, frame measurements and status pulses
    always_ff @(posedge tft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            h_active    <= '0;
            v_active    <= '0;
            fmt_locked  <= 1'b0;
            fmt_err     <= 1'b0;
        end else begin
            pix_valid   <= pix_ok;
            if (pix_ok) begin
                pix_data <= rgb_s1;
                pix_x    <= col;
                pix_y    <= row;
            end
            frame_start <= vs_rise;
            if (vs_rise) begin
                h_active <= first_len;
                v_active <= row;
            end
            fmt_locked  <= (state == ST_LOCKED);
            fmt_err     <= timeout_hit | (vs_rise & (state != ST_UNLOCK) & ~frame_good);
        end
    end

endmodule

// File: tb/tb_tft_rx.sv
// tb/tb_tft_rx.sv - directed self-checking bench for tft_rx
module tb_tft_rx;

    localparam int H  = 8;
    localparam int V  = 6;
    localparam int TO = 1500;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] rgb = '0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        tft_de = 1'b0;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic [9:0]  pix_x, pix_y, h_active, v_active;
    logic        frame_start, fmt_locked, fmt_err;

    tft_rx #(.EXP_H(H), .EXP_V(V), .VS_ACT(1'b0), .TIMEOUT(TO)) dut (
        .tft_clk(clk), .sys_rst_n(rst_n), .rgb(rgb), .hsync(hsync), .vsync(vsync),
        .tft_de(tft_de), .pix_data(pix_data), .pix_valid(pix_valid), .pix_x(pix_x),
        .pix_y(pix_y), .frame_start(frame_start), .h_active(h_active),
        .v_active(v_active), .fmt_locked(fmt_locked), .fmt_err(fmt_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [15:0] d;
        logic [9:0]  x;
        logic [9:0]  y;
    } pix_t;

    pix_t p1 = '0, p2 = '0;
    int   vectors = 0, miscompares = 0;
    int   fs_cnt = 0, err_cnt = 0;
    bit   fs_pend = 0;
    logic fs_err [0:31];
    logic fs_lk  [0:31];
    logic [9:0] fs_h [0:31];
    logic [9:0] fs_v [0:31];
    int   e0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: compare outputs due from two cycles ago, log frame events, drive next inputs
    task automatic tick(input logic de, input logic [15:0] d, input logic vs,
                        input logic ev, input logic [9:0] ex, input logic [9:0] ey);
        pix_t n;
        @(negedge clk);
        check("pix_valid", {63'd0, pix_valid}, {63'd0, p2.v});
        if (p2.v) begin
            check("pix_data", {48'd0, pix_data}, {48'd0, p2.d});
            check("pix_x", {54'd0, pix_x}, {54'd0, p2.x});
            check("pix_y", {54'd0, pix_y}, {54'd0, p2.y});
        end
        if (fmt_err) err_cnt++;
        if (frame_start) begin
            fs_cnt++;
            fs_err[fs_cnt % 32] = fmt_err;
            fs_h[fs_cnt % 32]   = h_active;
            fs_v[fs_cnt % 32]   = v_active;
            fs_pend = 1;
        end else if (fs_pend) begin
            fs_lk[fs_cnt % 32] = fmt_locked;
            fs_pend = 0;
        end
        tft_de = de;
        rgb    = de ? d : 16'h0000;
        vsync  = vs;
        hsync  = ~de;
        n.v = ev; n.d = d; n.x = ex; n.y = ey;
        p2 = p1;
        p1 = n;
    endtask

    task automatic frame(input int nl, input int len, input int bad_l, input int bad_len, input bit viol);
        int yo;
        int ll;
        logic [15:0] dv;
        yo = viol ? 1 : 0;
        for (int i = 0; i < 2; i++) tick(viol, 16'h1234, 1'b0, 1'b0, 10'd0, 10'd0);
        for (int i = 0; i < 2; i++) tick(1'b0, 16'h0, 1'b1, 1'b0, 10'd0, 10'd0);
        for (int l = 0; l < nl; l++) begin
            ll = (l == bad_l) ? bad_len : len;
            for (int c = 0; c < ll; c++) begin
                dv = (l == 5 && c == 7) ? 16'hF800 : 16'(((l & 63) << 10) | (c & 1023));
                tick(1'b1, dv, 1'b1, 1'b1, 10'((c > 1023) ? 1023 : c), 10'(l + yo));
            end
            for (int i = 0; i < 3; i++) tick(1'b0, 16'h0, 1'b1, 1'b0, 10'd0, 10'd0);
        end
    endtask

    task automatic good(input int n);
        for (int i = 0; i < n; i++) frame(V, H, -1, 0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 1'b1, 1'b0, 10'd0, 10'd0);
    endtask

    task automatic fs_check(input int idx, input logic exp_err, input logic exp_lk);
        string s;
        s = $sformatf("fs%0d_err", idx);
        check(s, {63'd0, fs_err[idx % 32]}, {63'd0, exp_err});
        s = $sformatf("fs%0d_locked", idx);
        check(s, {63'd0, fs_lk[idx % 32]}, {63'd0, exp_lk});
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_outputs", {4'd0, pix_valid, pix_data, pix_x, pix_y, frame_start,
                              h_active, v_active, fmt_locked, fmt_err}, 64'd0);
        p1 = '0;
        p2 = '0;
        idle(3);
        check("rst_locked", {63'd0, fmt_locked}, 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        idle(3);
        check("rst_outputs", {4'd0, pix_valid, pix_data, pix_x, pix_y, frame_start,
                              h_active, v_active, fmt_locked, fmt_err}, 64'd0);
        rst_n = 1'b1;
        idle(4);

        // three ideal frames: lock one cycle after the third frame_start
        good(3);
        check("fs2_h", {54'd0, fs_h[2]}, 64'd8);
        check("fs2_v", {54'd0, fs_v[2]}, 64'd6);
        fs_check(2, 1'b0, 1'b0);
        check("fs3_locked_at", 64'(fs_cnt), 64'd3);
        fs_check(3, 1'b0, 1'b1);
        check("no_err_lock", 64'(err_cnt), 64'd0);

        // short line breaks lock; two good frames restore it
        frame(V, H, 2, H - 1, 1'b0);
        good(3);
        fs_check(4, 1'b0, 1'b1);
        fs_check(5, 1'b1, 1'b0);
        check("fs5_h", {54'd0, fs_h[5]}, 64'd8);
        fs_check(6, 1'b0, 1'b0);
        fs_check(7, 1'b0, 1'b1);
        check("err_short", 64'(err_cnt), 64'd1);

        // column saturation at 1023 marks the frame bad
        frame(1, 1030, -1, 0, 1'b0);
        good(3);
        fs_check(9, 1'b1, 1'b0);
        check("fs9_h_sat", {54'd0, fs_h[9]}, 64'd1023);
        check("fs9_v", {54'd0, fs_v[9]}, 64'd1);
        fs_check(11, 1'b0, 1'b1);

        // de asserted during vsync: pixels dropped, frame bad
        frame(V, H, -1, 0, 1'b1);
        good(3);
        fs_check(12, 1'b0, 1'b1);
        fs_check(13, 1'b1, 1'b0);
        fs_check(15, 1'b0, 1'b1);

        // timeout while locked: a single fmt_err pulse, lock lost
        e0 = err_cnt;
        idle(TO + 200);
        check("timeout_err", 64'(err_cnt - e0), 64'd1);
        check("timeout_unlock", {63'd0, fmt_locked}, 64'd0);
        idle(TO + 100);
        check("timeout_once", 64'(err_cnt - e0), 64'd1);
        // UNLOCK: next vsync only arms checking, no judgement
        good(3);
        fs_check(16, 1'b0, 1'b0);
        fs_check(17, 1'b0, 1'b0);
        fs_check(18, 1'b0, 1'b1);
        check("timeout_err_after", 64'(err_cnt - e0), 64'd1);

        // mid-frame reset while locked: relock only after three vsyncs
        frame(2, H, -1, 0, 1'b0);
        fs_check(19, 1'b0, 1'b1);
        do_reset();
        e0 = err_cnt;
        idle(4);
        good(3);
        fs_check(20, 1'b0, 1'b0);
        fs_check(21, 1'b0, 1'b0);
        fs_check(22, 1'b0, 1'b1);
        check("reset_no_err", 64'(err_cnt - e0), 64'd0);
        check("fs_total", 64'(fs_cnt), 64'd22);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
